// File: rtl/react_pkg.sv
// Shared definitions for the reaction-time game controller.
//   - screen codes driven on reactScreen (consumed by the VGA controller)
//   - score saturation value
//   - FSM state enumeration
package react_pkg;

  localparam logic [1:0] SCR_IDLE  = 2'd0;
  localparam logic [1:0] SCR_WAIT  = 2'd1;
  localparam logic [1:0] SCR_GO    = 2'd2;
  localparam logic [1:0] SCR_SCORE = 2'd3;

  localparam logic [11:0] SCORE_MAX = 12'd4095;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GO,
    ST_SCORE
  } state_t;

endpackage

// File: rtl/lfsr_rng.sv
// 11-bit Fibonacci LFSR, polynomial x^11 + x^9 + 1 (maximal length, 2047
// states). Used as the random part of the red-screen delay.
// Ports:
//   clk    in   system clock
//   iReset in   synchronous active-high reset, loads SEED
//   en     in   advance one step when high
//   value  out  current LFSR state, never zero for a non-zero SEED
module lfsr_rng #(
  parameter logic [10:0] SEED = 11'h001
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        en,
  output logic [10:0] value
);

  always_ff @(posedge clk) begin
    if (iReset) begin
      value <= SEED;
    end else if (en) begin
      // taps at bit 11 and bit 9 of the polynomial -> indices 10 and 8
      value <= {value[9:0], value[10] ^ value[8]};
    end
  end

endmodule

// File: rtl/reaction_game_fsm.sv
// Game-flow controller for the reaction-time benchmark.
// Turns the debounced button into a screen selection and a millisecond
// reaction score for the downstream VGA controller.
// Ports:
//   clk          in   system clock
//   iReset       in   synchronous active-high reset
//   keyPress     in   debounced button level, active-high
//   reactScreen  out  0 idle/blue, 1 wait/red, 2 go/green, 3 score
//   currentScore out  last reaction time in ms (4095 = timed out)
//   bestScore    out  minimum valid score since reset (4095 = none yet)
//   tooEarly     out  set when the button is pressed during red
//   timedOut     out  set when the go phase saturates
module reaction_game_fsm
  import react_pkg::*;
#(
  parameter int          MS_DIV       = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [10:0] LFSR_SEED    = 11'h001
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        keyPress,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic [11:0] bestScore,
  output logic        tooEarly,
  output logic        timedOut
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  state_t      state;
  logic        kp_q;
  logic [PW-1:0] prescaler;
  logic [12:0] delay;
  logic [11:0] ms_count;
  logic [10:0] lfsr;
  logic        press;
  logic        tick;

  // Free-running random source; it keeps shifting in every state so the
  // value sampled at the start press depends on how long the player idled.
  lfsr_rng #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .iReset (iReset),
    .en     (1'b1),
    .value  (lfsr)
  );

  assign press = keyPress & ~kp_q;
  assign tick  = (prescaler == PW'(MS_DIV - 1));

  always_ff @(posedge clk) begin
    if (iReset) begin
      state        <= ST_IDLE;
      reactScreen  <= SCR_IDLE;
      currentScore <= '0;
      bestScore    <= SCORE_MAX;
      tooEarly     <= 1'b0;
      timedOut     <= 1'b0;
      kp_q         <= 1'b0;
      prescaler    <= '0;
      delay        <= '0;
      ms_count     <= '0;
    end else begin
      kp_q      <= keyPress;
      prescaler <= tick ? '0 : prescaler + 1'b1;

      case (state)
        ST_IDLE: begin
          if (press) begin
            state       <= ST_WAIT;
            reactScreen <= SCR_WAIT;
            delay       <= 13'(MIN_DELAY_MS) + {2'b00, lfsr};
            tooEarly    <= 1'b0;
            timedOut    <= 1'b0;
            // realign the ms timebase so the delay is exact
            prescaler   <= '0;
          end
        end

        ST_WAIT: begin
          // a press on the final tick still counts as too early
          if (press) begin
            state       <= ST_IDLE;
            reactScreen <= SCR_IDLE;
            tooEarly    <= 1'b1;
          end else if (tick) begin
            if (delay == 13'd1) begin
              state       <= ST_GO;
              reactScreen <= SCR_GO;
              ms_count    <= '0;
              prescaler   <= '0;
            end else begin
              delay <= delay - 13'd1;
            end
          end
        end

        ST_GO: begin
          // press beats a coincident tick: score is the pre-increment count
          if (press) begin
            state        <= ST_SCORE;
            reactScreen  <= SCR_SCORE;
            currentScore <= ms_count;
            if (ms_count < bestScore) begin
              bestScore <= ms_count;
            end
          end else if (tick) begin
            if (ms_count == SCORE_MAX - 12'd1) begin
              state        <= ST_SCORE;
              reactScreen  <= SCR_SCORE;
              currentScore <= SCORE_MAX;
              timedOut     <= 1'b1;
            end else begin
              ms_count <= ms_count + 12'd1;
            end
          end
        end

        ST_SCORE: begin
          if (press) begin
            state       <= ST_IDLE;
            reactScreen <= SCR_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          reactScreen <= SCR_IDLE;
        end
      endcase
    end
  end

endmodule
